// File: rtl/axil_multi_adder.sv
// ---------------------------------------------------------------------------
// axil_multi_adder
//   AXI4-Lite slave with NUM_CH independent add/subtract channels.
//
//   Register map (byte addresses, low two address bits ignored):
//     0x10*c + 0x0  A       (RW, byte-maskable)
//     0x10*c + 0x4  B       (RW, byte-maskable)
//     0x10*c + 0x8  RESULT  (RO)
//     0x10*c + 0xC  STATUS  (RO: bit0 carry/borrow, bit1 signed overflow, bit2 valid)
//     0xF0          CTRL    (RW: bit c = subtract for channel c,
//                            bit NUM_CH+c = saturate for channel c when
//                            ADDER_SAT_EN is defined)
//
//   Optional feature macro: ADDER_SAT_EN (signed saturation per channel).
//
//   Ports:
//     s1_axi_aclk / s1_axi_aresetn     clock, async active-low reset
//     s1_axi_aw* / s1_axi_w* / s1_axi_b*   write address, data, response
//     s1_axi_ar* / s1_axi_r*               read address, read data
// ---------------------------------------------------------------------------
module axil_multi_adder #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8,
  parameter int NUM_CH     = 4
) (
  input  logic                    s1_axi_aclk,
  input  logic                    s1_axi_aresetn,
  input  logic [ADDR_WIDTH-1:0]   s1_axi_awaddr,
  input  logic                    s1_axi_awvalid,
  output logic                    s1_axi_awready,
  input  logic [DATA_WIDTH-1:0]   s1_axi_wdata,
  input  logic [DATA_WIDTH/8-1:0] s1_axi_wstrb,
  input  logic                    s1_axi_wvalid,
  output logic                    s1_axi_wready,
  output logic [1:0]              s1_axi_bresp,
  output logic                    s1_axi_bvalid,
  input  logic                    s1_axi_bready,
  input  logic [ADDR_WIDTH-1:0]   s1_axi_araddr,
  input  logic                    s1_axi_arvalid,
  output logic                    s1_axi_arready,
  output logic [DATA_WIDTH-1:0]   s1_axi_rdata,
  output logic [1:0]              s1_axi_rresp,
  output logic                    s1_axi_rvalid,
  input  logic                    s1_axi_rready
);

  localparam int SW   = DATA_WIDTH / 8;
  localparam int CH_W = ADDR_WIDTH - 4;
  localparam int MSB  = DATA_WIDTH - 1;
`ifdef ADDER_SAT_EN
  localparam int CTRL_BITS = 2 * NUM_CH;
`else
  localparam int CTRL_BITS = NUM_CH;
`endif
  localparam logic [ADDR_WIDTH-3:0] CTRL_WORD = (ADDR_WIDTH-2)'(60);  // 0xF0 >> 2
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  function automatic logic [DATA_WIDTH-1:0] ctrl_mask_f();
    logic [DATA_WIDTH-1:0] m;
    m = '0;
    for (int i = 0; i < CTRL_BITS; i++) m[i] = 1'b1;
    return m;
  endfunction

  localparam logic [DATA_WIDTH-1:0] CTRL_MASK = ctrl_mask_f();

  function automatic logic [DATA_WIDTH-1:0] apply_strb(
    input logic [DATA_WIDTH-1:0] old_v,
    input logic [DATA_WIDTH-1:0] new_v,
    input logic [SW-1:0]         strb
  );
    logic [DATA_WIDTH-1:0] r;
    r = old_v;
    for (int i = 0; i < SW; i++)
      if (strb[i]) r[8*i +: 8] = new_v[8*i +: 8];
    return r;
  endfunction

  // Returns {overflow, carry, result}.
  function automatic logic [DATA_WIDTH+1:0] calc(
    input logic [DATA_WIDTH-1:0] a,
    input logic [DATA_WIDTH-1:0] b,
    input logic                  sub,
    input logic                  sat
  );
    logic [DATA_WIDTH:0]   s;
    logic [DATA_WIDTH-1:0] r;
    logic                  ovf;
    s   = sub ? ({1'b0, a} - {1'b0, b}) : ({1'b0, a} + {1'b0, b});
    ovf = (sub ? (a[MSB] != b[MSB]) : (a[MSB] == b[MSB])) && (s[MSB] != a[MSB]);
    r   = s[DATA_WIDTH-1:0];
    // Overflow direction follows the sign of A: positive A can only overflow upward.
    if (sat && ovf) r = a[MSB] ? {1'b1, {(DATA_WIDTH-1){1'b0}}} : {1'b0, {(DATA_WIDTH-1){1'b1}}};
    return {ovf, s[DATA_WIDTH], r};
  endfunction

  typedef enum logic { W_IDLE, W_RESP } w_state_e;
  typedef enum logic { R_IDLE, R_DATA } r_state_e;

  w_state_e              w_state_q;
  r_state_e              r_state_q;
  logic                  awready_q, wready_q, aw_held_q, w_held_q;
  logic                  bvalid_q, rvalid_q;
  logic [1:0]            bresp_q, rresp_q;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic [ADDR_WIDTH-1:0] awaddr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [SW-1:0]         wstrb_q;

  logic [DATA_WIDTH-1:0] a_q   [NUM_CH];
  logic [DATA_WIDTH-1:0] b_q   [NUM_CH];
  logic [DATA_WIDTH-1:0] res_q [NUM_CH];
  logic [2:0]            stat_q[NUM_CH];
  logic [DATA_WIDTH-1:0] ctrl_q;
  logic [NUM_CH-1:0]     pend_q;

  // Write-side combinational decode
  logic                  aw_hs, w_hs, commit;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [DATA_WIDTH-1:0] wr_data;
  logic [SW-1:0]         wr_strb;
  logic [ADDR_WIDTH-3:0] wr_word;
  logic [CH_W-1:0]       wr_ch;
  logic                  wr_is_ctrl, wr_ok;
  logic [NUM_CH-1:0]     wr_hit, ctrl_chg, launch_ab, launch;
  logic [DATA_WIDTH-1:0] ctrl_d;

  // Read-side combinational decode
  logic [ADDR_WIDTH-3:0] rd_word;
  logic [CH_W-1:0]       rd_ch;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  rd_ok;

  assign aw_hs   = s1_axi_awvalid && awready_q;
  assign w_hs    = s1_axi_wvalid && wready_q;
  assign commit  = (w_state_q == W_IDLE) && (aw_held_q || aw_hs) && (w_held_q || w_hs);
  assign wr_addr = aw_held_q ? awaddr_q : s1_axi_awaddr;
  assign wr_data = w_held_q  ? wdata_q  : s1_axi_wdata;
  assign wr_strb = w_held_q  ? wstrb_q  : s1_axi_wstrb;
  assign wr_word = wr_addr[ADDR_WIDTH-1:2];
  assign wr_ch   = wr_word[ADDR_WIDTH-3:2];
  assign rd_word = s1_axi_araddr[ADDR_WIDTH-1:2];
  assign rd_ch   = rd_word[ADDR_WIDTH-3:2];

  logic unused_ok;
  assign unused_ok = ^{wr_addr[1:0], s1_axi_araddr[1:0]};

  always_comb begin
    wr_is_ctrl = (wr_word == CTRL_WORD);
    wr_hit     = '0;
    ctrl_chg   = '0;
    ctrl_d     = apply_strb(ctrl_q, wr_data, wr_strb) & CTRL_MASK;
    for (int c = 0; c < NUM_CH; c++) begin
      wr_hit[c]   = !wr_is_ctrl && (wr_ch == CH_W'(c)) && !wr_word[1];
      ctrl_chg[c] = ctrl_d[c] ^ ctrl_q[c];
`ifdef ADDER_SAT_EN
      // Toggling saturation also changes the visible result, so relaunch too.
      ctrl_chg[c] = ctrl_chg[c] | (ctrl_d[NUM_CH+c] ^ ctrl_q[NUM_CH+c]);
`endif
    end
    wr_ok     = wr_is_ctrl || (|wr_hit);
    launch_ab = commit ? wr_hit : '0;
    launch    = launch_ab | ((commit && wr_is_ctrl) ? ctrl_chg : '0);
  end

  always_comb begin
    rd_data = '0;
    rd_ok   = 1'b0;
    if (rd_word == CTRL_WORD) begin
      rd_data = ctrl_q;
      rd_ok   = 1'b1;
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (rd_ch == CH_W'(c)) begin
          rd_ok = 1'b1;
          case (rd_word[1:0])
            2'd0:    rd_data = a_q[c];
            2'd1:    rd_data = b_q[c];
            2'd2:    rd_data = res_q[c];
            default: rd_data = {{(DATA_WIDTH-3){1'b0}}, stat_q[c]};
          endcase
        end
      end
    end
  end

  // Write FSM: AW and W captured independently, commit once both are held.
  always_ff @(posedge s1_axi_aclk or negedge s1_axi_aresetn) begin
    if (!s1_axi_aresetn) begin
      w_state_q <= W_IDLE;
      awready_q <= 1'b1;
      wready_q  <= 1'b1;
      aw_held_q <= 1'b0;
      w_held_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      bresp_q   <= RESP_OKAY;
      awaddr_q  <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
    end else begin
      case (w_state_q)
        W_IDLE: begin
          if (aw_hs) begin
            awready_q <= 1'b0;
            aw_held_q <= 1'b1;
            awaddr_q  <= s1_axi_awaddr;
          end
          if (w_hs) begin
            wready_q <= 1'b0;
            w_held_q <= 1'b1;
            wdata_q  <= s1_axi_wdata;
            wstrb_q  <= s1_axi_wstrb;
          end
          if (commit) begin
            w_state_q <= W_RESP;
            aw_held_q <= 1'b0;
            w_held_q  <= 1'b0;
            bvalid_q  <= 1'b1;
            bresp_q   <= wr_ok ? RESP_OKAY : RESP_SLVERR;
          end
        end
        default: begin
          if (s1_axi_bready) begin
            w_state_q <= W_IDLE;
            bvalid_q  <= 1'b0;
            awready_q <= 1'b1;
            wready_q  <= 1'b1;
          end
        end
      endcase
    end
  end

  // Read FSM
  always_ff @(posedge s1_axi_aclk or negedge s1_axi_aresetn) begin
    if (!s1_axi_aresetn) begin
      r_state_q <= R_IDLE;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
      rresp_q   <= RESP_OKAY;
    end else begin
      case (r_state_q)
        R_IDLE: begin
          if (s1_axi_arvalid && s1_axi_arready) begin
            r_state_q <= R_DATA;
            rvalid_q  <= 1'b1;
            rdata_q   <= rd_data;
            rresp_q   <= rd_ok ? RESP_OKAY : RESP_SLVERR;
          end
        end
        default: begin
          if (s1_axi_rready) begin
            r_state_q <= R_IDLE;
            rvalid_q  <= 1'b0;
          end
        end
      endcase
    end
  end

  // Register file and compute pipeline: a launched channel computes on the
  // following clock from the already-updated operands and CTRL.
  always_ff @(posedge s1_axi_aclk or negedge s1_axi_aresetn) begin
    if (!s1_axi_aresetn) begin
      for (int c = 0; c < NUM_CH; c++) begin
        a_q[c]    <= '0;
        b_q[c]    <= '0;
        res_q[c]  <= '0;
        stat_q[c] <= '0;
      end
      ctrl_q <= '0;
      pend_q <= '0;
    end else begin
      pend_q <= launch;
      for (int c = 0; c < NUM_CH; c++) begin
        if (pend_q[c]) begin
          logic [DATA_WIDTH+1:0] r;
          logic                  sat;
`ifdef ADDER_SAT_EN
          sat = ctrl_q[NUM_CH+c];
`else
          sat = 1'b0;
`endif
          r = calc(a_q[c], b_q[c], ctrl_q[c], sat);
          res_q[c]  <= r[DATA_WIDTH-1:0];
          stat_q[c] <= {1'b1, r[DATA_WIDTH+1], r[DATA_WIDTH]};
        end
        if (wr_hit[c] && commit) begin
          if (wr_word[0]) b_q[c] <= apply_strb(b_q[c], wr_data, wr_strb);
          else            a_q[c] <= apply_strb(a_q[c], wr_data, wr_strb);
        end
        // An operand write invalidates any result, including one landing now.
        if (launch_ab[c]) stat_q[c][2] <= 1'b0;
      end
      if (commit && wr_is_ctrl) ctrl_q <= ctrl_d;
    end
  end

  assign s1_axi_awready = awready_q;
  assign s1_axi_wready  = wready_q;
  assign s1_axi_bvalid  = bvalid_q;
  assign s1_axi_bresp   = bresp_q;
  // Holding AR off while any result is in flight keeps RESULT/STATUS coherent.
  assign s1_axi_arready = (r_state_q == R_IDLE) && !(|pend_q);
  assign s1_axi_rvalid  = rvalid_q;
  assign s1_axi_rdata   = rdata_q;
  assign s1_axi_rresp   = rresp_q;

endmodule
